// File: rtl/algorithm_multi_vc.sv
// Per-input routing stage of the NoC router with VC_NUM virtual channels per direction.
// A header flit selects an output (direction, VC) channel, which is latched for the rest
// of the packet (wormhole). Stray non-header flits arriving while idle are dropped and
// counted with a saturating counter.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_t*_i / in_tready_o   input AXI-Stream flit
//   out_t*_o / out_tready_i per-channel output streams, channel = dir*VC_NUM + vc
//   current_grant_i         VC hint, low log2(VC_NUM) bits pick the VC
//   target_x_i, target_y_i  header destination coordinates
//   lock_i                  channel already owned by another input
//   owner_o                 one-hot channel owned by this input (PKT state only)
//   drop_o, drop_count_o    registered drop pulse and saturating drop count
module algorithm_multi_vc #(
  parameter int unsigned          DATA_WIDTH           = 32,
  parameter int unsigned          ID_WIDTH             = 4,
  parameter logic [ID_WIDTH-1:0]  ROUTING_HEADER       = 4'hF,
  parameter int unsigned          VC_NUM               = 2,
  parameter int unsigned          CHANNEL_NUMBER       = 5 * VC_NUM,
  parameter int unsigned          CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int unsigned          MAX_ROUTERS_X        = 4,
  parameter int unsigned          MAX_ROUTERS_Y        = 4,
  parameter int unsigned          ROUTER_X             = 0,
  parameter int unsigned          ROUTER_Y             = 0,
  parameter int unsigned          ROUTING_MODE         = 0
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     in_tvalid_i,
  input  logic [DATA_WIDTH-1:0]                    in_tdata_i,
  input  logic [ID_WIDTH-1:0]                      in_tid_i,
  input  logic                                     in_tlast_i,
  output logic                                     in_tready_o,
  output logic [CHANNEL_NUMBER-1:0]                out_tvalid_o,
  output logic [CHANNEL_NUMBER*DATA_WIDTH-1:0]     out_tdata_o,
  output logic [CHANNEL_NUMBER*ID_WIDTH-1:0]       out_tid_o,
  output logic [CHANNEL_NUMBER-1:0]                out_tlast_o,
  input  logic [CHANNEL_NUMBER-1:0]                out_tready_i,
  input  logic [CHANNEL_NUMBER_WIDTH-1:0]          current_grant_i,
  input  logic [$clog2(MAX_ROUTERS_X)-1:0]         target_x_i,
  input  logic [$clog2(MAX_ROUTERS_Y)-1:0]         target_y_i,
  input  logic [CHANNEL_NUMBER-1:0]                lock_i,
  output logic [CHANNEL_NUMBER-1:0]                owner_o,
  output logic                                     drop_o,
  output logic [15:0]                              drop_count_o
);

  localparam int unsigned XW     = $clog2(MAX_ROUTERS_X);
  localparam int unsigned YW     = $clog2(MAX_ROUTERS_Y);
  localparam int unsigned CW     = CHANNEL_NUMBER_WIDTH;
  localparam int unsigned VcBits = $clog2(VC_NUM);

  localparam logic [XW-1:0] RouterX = XW'(ROUTER_X);
  localparam logic [YW-1:0] RouterY = YW'(ROUTER_Y);

  localparam logic [2:0] DirLocal = 3'd0;
  localparam logic [2:0] DirNorth = 3'd1;
  localparam logic [2:0] DirEast  = 3'd2;
  localparam logic [2:0] DirSouth = 3'd3;
  localparam logic [2:0] DirWest  = 3'd4;

  typedef enum logic [0:0] {StIdle, StPkt} state_e;

  state_e          state_q, state_d, state_eff;
  logic [CW-1:0]   route_q, route_d;
  logic            drop_q;
  logic [15:0]     drop_cnt_q;

  logic [2:0]      dir;
  logic [CW-1:0]   hdr_ch;
  logic [CW-1:0]   fwd_ch;
  logic            fwd_en;
  logic            drop_fire;
  logic            is_hdr;
  logic            unused_grant;

  assign is_hdr       = (in_tid_i == ROUTING_HEADER);
  assign unused_grant = ^current_grant_i;

  // Direction from destination; ROUTING_MODE picks which dimension resolves first.
  always_comb begin
    dir = DirLocal;
    if (ROUTING_MODE == 0) begin
      if (target_x_i != RouterX)      dir = (target_x_i > RouterX) ? DirEast : DirWest;
      else if (target_y_i != RouterY) dir = (target_y_i < RouterY) ? DirNorth : DirSouth;
    end else begin
      if (target_y_i != RouterY)      dir = (target_y_i < RouterY) ? DirNorth : DirSouth;
      else if (target_x_i != RouterX) dir = (target_x_i > RouterX) ? DirEast : DirWest;
    end
  end

  // With VC_NUM a power of two, dir*VC_NUM + vc is just {dir, vc}.
  if (VC_NUM > 1) begin : g_vc
    assign hdr_ch = CW'({dir, current_grant_i[VcBits-1:0]});
  end else begin : g_novc
    assign hdr_ch = CW'(dir);
  end

  // While reset is asserted the datapath behaves as if idle.
  assign state_eff = rst_i ? StIdle : state_q;

  always_comb begin
    out_tvalid_o = '0;
    out_tdata_o  = '0;
    out_tid_o    = '0;
    out_tlast_o  = '0;
    in_tready_o  = 1'b0;
    fwd_en       = 1'b0;
    fwd_ch       = hdr_ch;
    drop_fire    = 1'b0;
    state_d      = state_q;
    route_d      = route_q;

    unique case (state_eff)
      StIdle: begin
        if (in_tvalid_i) begin
          if (is_hdr) begin
            // A locked channel stalls the header without dropping it.
            if (!lock_i[hdr_ch]) begin
              fwd_en      = 1'b1;
              in_tready_o = out_tready_i[hdr_ch];
              // Single-flit packets never take ownership.
              if (in_tready_o && !in_tlast_i) begin
                state_d = StPkt;
                route_d = hdr_ch;
              end
            end
          end else begin
            in_tready_o = 1'b1;
            drop_fire   = 1'b1;
          end
        end
      end
      StPkt: begin
        fwd_en      = 1'b1;
        fwd_ch      = route_q;
        in_tready_o = out_tready_i[route_q];
        if (in_tvalid_i && in_tready_o && in_tlast_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (fwd_en) begin
      for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
        if (fwd_ch == CW'(i)) begin
          out_tvalid_o[i]                       = in_tvalid_i;
          out_tdata_o[i*DATA_WIDTH +: DATA_WIDTH] = in_tdata_i;
          out_tid_o[i*ID_WIDTH +: ID_WIDTH]       = in_tid_i;
          out_tlast_o[i]                        = in_tlast_i;
        end
      end
    end
  end

  always_comb begin
    owner_o = '0;
    for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
      owner_o[i] = (state_q == StPkt) && (route_q == CW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      route_q    <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      drop_q  <= drop_fire;
      if (drop_fire && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_o       = drop_q;
  assign drop_count_o = drop_cnt_q;

endmodule
